// File: rtl/glyph_pixel_pipeline_if.sv
// glyph_pixel_pipeline_if
//   Bundles the pixel stream, glyph-store write port and pixel output of
//   glyph_pixel_pipeline.
//
// Handshake: en is a pure valid qualifier with no ready. The pipeline
//   accepts a pixel on every rising clk where en=1 and never stalls.
//   pixel_valid is the same qualifier delayed by two cycles, and the
//   consumer must take pixel in every cycle where pixel_valid=1.
//
// Signals (master = text-buffer fetch side, slave = pipeline):
//   en, character, dot_count, scan_count    pixel address into the glyph store
//   fg_color, bg_color                      colour indices for this character
//   inverse, blink_attr, cursor_here        per-character attributes
//   frame_start                             one-cycle pulse per video frame
//   wr_en, wr_addr, wr_data                 glyph store write port ({glyph,row})
//   pixel, pixel_valid, blink_phase         outputs towards the VGA output mux
interface glyph_pixel_pipeline_if #(
  parameter int NUM_CHARS = 16,
  parameter int CHAR_W    = 8,
  parameter int CHAR_H    = 16,
  parameter int PIXEL_W   = 2
);
  localparam int CHAR_BITS = $clog2(NUM_CHARS);
  localparam int DOT_BITS  = $clog2(CHAR_W);
  localparam int SCAN_BITS = $clog2(CHAR_H);

  logic                           en;
  logic [CHAR_BITS-1:0]           character;
  logic [DOT_BITS-1:0]            dot_count;
  logic [SCAN_BITS-1:0]           scan_count;
  logic [PIXEL_W-1:0]             fg_color;
  logic [PIXEL_W-1:0]             bg_color;
  logic                           inverse;
  logic                           blink_attr;
  logic                           cursor_here;
  logic                           frame_start;
  logic                           wr_en;
  logic [CHAR_BITS+SCAN_BITS-1:0] wr_addr;
  logic [CHAR_W-1:0]              wr_data;
  logic [PIXEL_W-1:0]             pixel;
  logic                           pixel_valid;
  logic                           blink_phase;

  modport master (
    output en, character, dot_count, scan_count, fg_color, bg_color,
           inverse, blink_attr, cursor_here, frame_start,
           wr_en, wr_addr, wr_data,
    input  pixel, pixel_valid, blink_phase
  );

  modport slave (
    input  en, character, dot_count, scan_count, fg_color, bg_color,
           inverse, blink_attr, cursor_here, frame_start,
           wr_en, wr_addr, wr_data,
    output pixel, pixel_valid, blink_phase
  );
endinterface

// File: rtl/glyph_pixel_pipeline.sv
// glyph_pixel_pipeline
//   Two-stage glyph-to-colour pipeline. Stage 1 reads one row word of the
//   writable glyph store and registers the pixel attributes; stage 2 picks
//   the addressed dot, applies blink / cursor / inverse and registers the
//   colour index. A frame counter derives the blink phase from frame_start.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset; release is re-timed to clk
//   bus   glyph_pixel_pipeline_if.slave (pixel stream, write port, outputs)
//
// The glyph store has no reset, so fonts survive a reset.
module glyph_pixel_pipeline #(
  parameter int NUM_CHARS    = 16,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int PIXEL_W      = 2,
  parameter int BLINK_FRAMES = 30,
  parameter int CURSOR_ROWS  = 2
) (
  input logic                    clk,
  input logic                    rst,
  glyph_pixel_pipeline_if.slave  bus
);
  localparam int CHAR_BITS = $clog2(NUM_CHARS);
  localparam int DOT_BITS  = $clog2(CHAR_W);
  localparam int SCAN_BITS = $clog2(CHAR_H);
  localparam int ADDR_W    = CHAR_BITS + SCAN_BITS;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int FC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // ---------------------------------------------------------------------
  // Reset release re-timing. rst asserts the hold at once; the hold clears
  // two clock edges after rst falls, and while it is set every state
  // register loads its reset value.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_hold;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= rst_sync_d;
  end

  assign rst_hold = rst_sync_q[1];

  // ---------------------------------------------------------------------
  // Glyph store: synchronous read, single write port. Both the write and
  // the read use non-blocking updates in one process, so a same-cycle read
  // of the address being written returns the old word.
  // ---------------------------------------------------------------------
  logic [CHAR_W-1:0] glyph_mem [DEPTH];
  logic [CHAR_W-1:0] rd_row_q;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = {bus.character, bus.scan_count};

  always_ff @(posedge clk) begin
    if (bus.wr_en) glyph_mem[bus.wr_addr] <= bus.wr_data;
    if (bus.en)    rd_row_q <= glyph_mem[rd_addr];
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic                 s1_valid_q,  s1_valid_d;
  logic [DOT_BITS-1:0]  s1_dot_q,    s1_dot_d;
  logic [SCAN_BITS-1:0] s1_scan_q,   s1_scan_d;
  logic [PIXEL_W-1:0]   s1_fg_q,     s1_fg_d;
  logic [PIXEL_W-1:0]   s1_bg_q,     s1_bg_d;
  logic                 s1_inv_q,    s1_inv_d;
  logic                 s1_blink_q,  s1_blink_d;
  logic                 s1_cursor_q, s1_cursor_d;
  logic                 s1_range_q,  s1_range_d;

  always_comb begin
    s1_valid_d  = bus.en;
    s1_dot_d    = bus.dot_count;
    s1_scan_d   = bus.scan_count;
    s1_fg_d     = bus.fg_color;
    s1_bg_d     = bus.bg_color;
    s1_inv_d    = bus.inverse;
    s1_blink_d  = bus.blink_attr;
    s1_cursor_d = bus.cursor_here;
    // Only reachable for non power-of-two glyph counts or heights.
    s1_range_d  = (int'(bus.scan_count) >= CHAR_H) ||
                  (int'(bus.character) >= NUM_CHARS);
    if (rst_hold) begin
      s1_valid_d  = 1'b0;
      s1_dot_d    = '0;
      s1_scan_d   = '0;
      s1_fg_d     = '0;
      s1_bg_d     = '0;
      s1_inv_d    = 1'b0;
      s1_blink_d  = 1'b0;
      s1_cursor_d = 1'b0;
      s1_range_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_dot_q    <= '0;
      s1_scan_q   <= '0;
      s1_fg_q     <= '0;
      s1_bg_q     <= '0;
      s1_inv_q    <= 1'b0;
      s1_blink_q  <= 1'b0;
      s1_cursor_q <= 1'b0;
      s1_range_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dot_q    <= s1_dot_d;
      s1_scan_q   <= s1_scan_d;
      s1_fg_q     <= s1_fg_d;
      s1_bg_q     <= s1_bg_d;
      s1_inv_q    <= s1_inv_d;
      s1_blink_q  <= s1_blink_d;
      s1_cursor_q <= s1_cursor_d;
      s1_range_q  <= s1_range_d;
    end
  end

  // ---------------------------------------------------------------------
  // Blink frame counter and phase
  // ---------------------------------------------------------------------
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (bus.frame_start) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    if (rst_hold) begin
      frame_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: dot select, attributes, colour register
  // ---------------------------------------------------------------------
  logic [PIXEL_W-1:0]  pixel_q, pixel_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [DOT_BITS-1:0] dot_idx;
  logic                dot;
  logic [PIXEL_W-1:0]  eff_fg, eff_bg;

  always_comb begin
    // dot_count 0 is the leftmost dot, held in the row word's MSB.
    dot_idx = DOT_BITS'(CHAR_W - 1) - s1_dot_q;
    dot     = (int'(s1_dot_q) < CHAR_W) ? rd_row_q[dot_idx] : 1'b0;
    if (s1_blink_q && blink_phase_q) dot = 1'b0;
    // Cursor shares the blink phase: visible only in the shown phase.
    if (s1_cursor_q && !blink_phase_q &&
        (int'(s1_scan_q) >= CHAR_H - CURSOR_ROWS)) dot = 1'b1;

    eff_fg = s1_inv_q ? s1_bg_q : s1_fg_q;
    eff_bg = s1_inv_q ? s1_fg_q : s1_bg_q;

    pixel_valid_d = s1_valid_q;
    if (!s1_valid_q)     pixel_d = '0;
    else if (s1_range_q) pixel_d = eff_bg;
    else if (dot)        pixel_d = eff_fg;
    else                 pixel_d = eff_bg;

    if (rst_hold) begin
      pixel_valid_d = 1'b0;
      pixel_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.blink_phase = blink_phase_q;
endmodule

// File: tb/tb_glyph_pixel_pipeline.sv
// tb_glyph_pixel_pipeline
//   Directed bench for glyph_pixel_pipeline with BLINK_FRAMES=2. Inputs
//   change just after the falling edge; outputs are sampled on the falling
//   edge, so the pixel applied at falling edge k is observed at edge k+2.
module tb_glyph_pixel_pipeline;
  localparam int NUM_CHARS    = 16;
  localparam int CHAR_W       = 8;
  localparam int CHAR_H       = 16;
  localparam int PIXEL_W      = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int CURSOR_ROWS  = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic [PIXEL_W-1:0] exp_q[$];

  glyph_pixel_pipeline_if #(
    .NUM_CHARS(NUM_CHARS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .PIXEL_W(PIXEL_W)
  ) bus ();

  glyph_pixel_pipeline #(
    .NUM_CHARS(NUM_CHARS), .CHAR_W(CHAR_W), .CHAR_H(CHAR_H),
    .PIXEL_W(PIXEL_W), .BLINK_FRAMES(BLINK_FRAMES), .CURSOR_ROWS(CURSOR_ROWS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.en = 1'b0; bus.character = '0; bus.dot_count = '0; bus.scan_count = '0;
    bus.fg_color = '0; bus.bg_color = '0; bus.inverse = 1'b0;
    bus.blink_attr = 1'b0; bus.cursor_here = 1'b0; bus.frame_start = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
  endtask

  task automatic set_px(input logic e, input logic [3:0] ch, input logic [2:0] dot,
                        input logic [3:0] scan, input logic [1:0] fg, input logic [1:0] bg,
                        input logic inv, input logic blk, input logic cur);
    bus.en = e; bus.character = ch; bus.dot_count = dot; bus.scan_count = scan;
    bus.fg_color = fg; bus.bg_color = bg; bus.inverse = inv;
    bus.blink_attr = blk; bus.cursor_here = cur;
  endtask

  task automatic write_row(input logic [3:0] ch, input logic [3:0] row, input logic [7:0] data);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = {ch, row}; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    n_vec++; if (bus.pixel !== 2'd0) begin n_err++; $display("FAIL reset_pixel: got %0d want 0", bus.pixel); end
    n_vec++; if (bus.pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.pixel_valid); end
    n_vec++; if (bus.blink_phase !== 1'b0) begin n_err++; $display("FAIL reset_blink: got %b want 0", bus.blink_phase); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (bus.pixel_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", bus.pixel_valid); end
  endtask

  // Glyph 3 row 5 = 1010_0000, fg=2 bg=1, normal then inverse.
  task automatic test_basic(input logic inv);
    logic [1:0] plain [8] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [PIXEL_W-1:0] e;
    exp_q.delete();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        if (i < 10) begin
          n_vec++; if (bus.pixel_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid inv=%b dot=%0d: got %b want 1", inv, i-2, bus.pixel_valid); end
        end else begin
          n_vec++; if (bus.pixel_valid !== 1'b0) begin n_err++; $display("FAIL basic_tail_valid inv=%b: got %b want 0", inv, bus.pixel_valid); end
        end
        n_vec++; if (bus.pixel !== e) begin n_err++; $display("FAIL basic_pixel inv=%b idx=%0d: got %0d want %0d", inv, i-2, bus.pixel, e); end
      end
      if (i < 8) begin
        set_px(1'b1, 4'd3, 3'(i), 4'd5, 2'd2, 2'd1, inv, 1'b0, 1'b0);
        exp_q.push_back(inv ? (plain[i] == 2'd2 ? 2'd1 : 2'd2) : plain[i]);
      end else begin
        set_px(1'b0, 4'd3, 3'd0, 4'd5, 2'd2, 2'd1, inv, 1'b0, 1'b0);
        exp_q.push_back(2'd0);
      end
    end
  endtask

  // Glyph 5 row 0 all ones, blink_attr=1, fg=3 bg=1.
  task automatic test_blink();
    logic [1:0] mid [4] = '{2'd3, 2'd3, 2'd1, 2'd1};
    logic [PIXEL_W-1:0] e;
    write_row(4'd5, 4'd0, 8'hFF);
    for (int round = 0; round < 3; round++) begin
      // round 0: phase 0, round 1: phase 1, round 2: phase 0 again
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          e = exp_q.pop_front();
          n_vec++; if (bus.pixel !== e || bus.pixel_valid !== 1'b1) begin n_err++; $display("FAIL blink_pixel round=%0d: got %0d/%b want %0d/1", round, bus.pixel, bus.pixel_valid, e); end
        end
        if (i < 2) begin
          set_px(1'b1, 4'd5, 3'(i), 4'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
          exp_q.push_back((round == 1) ? 2'd1 : 2'd3);
        end else set_px(1'b0, 4'd5, 3'd0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
      end
      if (round < 2) begin
        pulse_frame();
        n_vec++; if (bus.blink_phase !== (round == 1)) begin n_err++; $display("FAIL blink_one_pulse round=%0d: got %b want %b", round, bus.blink_phase, round == 1); end
        pulse_frame();
        n_vec++; if (bus.blink_phase !== (round == 0)) begin n_err++; $display("FAIL blink_two_pulse round=%0d: got %b want %b", round, bus.blink_phase, round == 0); end
      end
    end
    // Toggle while streaming: pulse lands together with pixel 2.
    pulse_frame();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      if (i >= 2) begin
        e = exp_q.pop_front();
        n_vec++; if (bus.pixel !== e) begin n_err++; $display("FAIL blink_midframe idx=%0d: got %0d want %0d", i-2, bus.pixel, e); end
      end
      if (i < 4) begin
        set_px(1'b1, 4'd5, 3'(i), 4'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
        if (i == 2) bus.frame_start = 1'b1;
        exp_q.push_back(mid[i]);
      end else set_px(1'b0, 4'd5, 3'd0, 4'd0, 2'd3, 2'd1, 1'b0, 1'b1, 1'b0);
    end
    n_vec++; if (bus.blink_phase !== 1'b1) begin n_err++; $display("FAIL blink_midframe_phase: got %b want 1", bus.blink_phase); end
    pulse_frame(); pulse_frame();
  endtask

  // Glyph 6 rows 13/14 blank, cursor_here=1, fg=2 bg=1.
  task automatic test_cursor();
    logic [PIXEL_W-1:0] e;
    write_row(4'd6, 4'd13, 8'h00);
    write_row(4'd6, 4'd14, 8'h00);
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        n_vec++; if (bus.pixel !== e) begin n_err++; $display("FAIL cursor_pixel idx=%0d: got %0d want %0d", i-2, bus.pixel, e); end
      end
      if (i < 16) begin
        set_px(1'b1, 4'd6, 3'(i % 8), (i < 8) ? 4'd14 : 4'd13, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back((i < 8) ? 2'd2 : 2'd1);
      end else set_px(1'b0, 4'd6, 3'd0, 4'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    end
    pulse_frame(); pulse_frame();
    n_vec++; if (bus.blink_phase !== 1'b1) begin n_err++; $display("FAIL cursor_phase: got %b want 1", bus.blink_phase); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        n_vec++; if (bus.pixel !== 2'd1) begin n_err++; $display("FAIL cursor_hidden: got %0d want 1", bus.pixel); end
      end
      if (i == 0) set_px(1'b1, 4'd6, 3'd3, 4'd14, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1);
      else        set_px(1'b0, 4'd6, 3'd0, 4'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    end
    pulse_frame(); pulse_frame();
  endtask

  // Glyph 7 row 2 written 0xFF while being read (old value 0x00).
  task automatic test_read_before_write();
    write_row(4'd7, 4'd2, 8'h00);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 8'h72; bus.wr_data = 8'hFF;
    set_px(1'b1, 4'd7, 3'd0, 4'd2, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    set_px(1'b1, 4'd7, 3'd0, 4'd2, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.pixel !== 2'd1 || bus.pixel_valid !== 1'b1) begin n_err++; $display("FAIL rbw_old: got %0d/%b want 1/1", bus.pixel, bus.pixel_valid); end
    set_px(1'b0, 4'd7, 3'd0, 4'd2, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.pixel !== 2'd2 || bus.pixel_valid !== 1'b1) begin n_err++; $display("FAIL rbw_new: got %0d/%b want 2/1", bus.pixel, bus.pixel_valid); end
  endtask

  // Reset pulse in the middle of a glyph 3 row 5 stream, blink phase 1.
  task automatic test_reset_mid_stream();
    logic [1:0] plain [8] = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    pulse_frame(); pulse_frame();
    n_vec++; if (bus.blink_phase !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_phase: got %b want 1", bus.blink_phase); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_px(1'b1, 4'd3, 3'(i), 4'd5, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    n_vec++; if (bus.pixel_valid !== 1'b1 || bus.pixel !== plain[2]) begin n_err++; $display("FAIL rstmid_pre_pixel: got %0d/%b want %0d/1", bus.pixel, bus.pixel_valid, plain[2]); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.pixel !== 2'd0) begin n_err++; $display("FAIL rstmid_pixel: got %0d want 0", bus.pixel); end
    n_vec++; if (bus.pixel_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.pixel_valid); end
    n_vec++; if (bus.blink_phase !== 1'b0) begin n_err++; $display("FAIL rstmid_blink: got %b want 0", bus.blink_phase); end
    @(negedge clk);
    rst = 1'b0;
    set_px(1'b0, 4'd3, 3'd0, 4'd5, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (bus.pixel_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_flushed idx=%0d: got %b want 0", i, bus.pixel_valid); end
    end
    set_px(1'b1, 4'd3, 3'd0, 4'd5, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.pixel_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_lat1: got %b want 0", bus.pixel_valid); end
    set_px(1'b1, 4'd3, 3'd1, 4'd5, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.pixel_valid !== 1'b1 || bus.pixel !== 2'd2) begin n_err++; $display("FAIL rstmid_first: got %0d/%b want 2/1", bus.pixel, bus.pixel_valid); end
    set_px(1'b0, 4'd3, 3'd0, 4'd5, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (bus.pixel_valid !== 1'b1 || bus.pixel !== 2'd1) begin n_err++; $display("FAIL rstmid_second: got %0d/%b want 1/1", bus.pixel, bus.pixel_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    write_row(4'd3, 4'd5, 8'b1010_0000);
    test_basic(1'b0);
    test_basic(1'b1);
    test_blink();
    test_cursor();
    test_read_before_write();
    test_reset_mid_stream();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
